// File: rtl/mem_arb_pkg.sv
// Shared types and line geometry for the memory-port arbiter, both caches and the memory model.
package mem_arb_pkg;

    localparam int LINE_ADDR_W = 28;
    localparam int LINE_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_I  = 2'd1,
        BUSY_D  = 2'd2,
        RELEASE = 2'd3
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational round-robin pick; bit 0 = I side, bit 1 = D side.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  grant_e     last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // on a tie the side that was not served last wins
            2'b11:   gnt_o = (last_i == GNT_I) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one off-chip line port between I-cache and D-cache refills/write-backs, one
// transaction at a time, round-robin on ties, with a dead RELEASE cycle after each.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = LINE_ADDR_W,
    parameter int DATA_W  = LINE_DATA_W,
    parameter bit D_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam grant_e LAST_RST = D_FIRST ? GNT_I : GNT_D;

    state_e            state_q,     state_d;
    grant_e            last_q,      last_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        gnt;

    rr_arb2 u_rr_arb2 (
        .req_i  ({d_read | d_write, i_read}),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= LAST_RST;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (gnt[1]) begin
                    // a write-back goes first; a held read re-arbitrates afterwards
                    state_d     = BUSY_D;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_write_d = d_write;
                    mem_read_d  = ~d_write;
                end else if (gnt[0]) begin
                    state_d     = BUSY_I;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    state_d     = RELEASE;
                    last_d      = GNT_I;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    state_d     = RELEASE;
                    last_d      = GNT_D;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign i_ready   = (state_q == BUSY_I) & mem_ready;
    assign d_ready   = (state_q == BUSY_D) & mem_ready;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_mem_port_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, d_read, d_write, mem_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic          i_ready, d_ready, mem_read, mem_write;
    logic [AW-1:0] mem_addr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        #1;
        n_cmp++; if (mem_read !== 1'b0)  begin n_err++; $display("FAIL rst_mem_read: got %0b want 0", mem_read); end
        n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rst_mem_write: got %0b want 0", mem_write); end
        n_cmp++; if (mem_addr !== '0)    begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== '0)   begin n_err++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        n_cmp++; if ({i_ready, d_ready} !== 2'b00) begin n_err++; $display("FAIL rst_ready: got %b want 00", {i_ready, d_ready}); end
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_i_only;
        i_read = 1'b1; i_addr = 28'h0000010;
        #1;
        n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL ionly_latency: mem_read=%0b want 0", mem_read); end
        tick;
        n_cmp++; if (mem_read !== 1'b1)  begin n_err++; $display("FAIL ionly_read: got %0b want 1", mem_read); end
        n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL ionly_write: got %0b want 0", mem_write); end
        n_cmp++; if (mem_addr !== 28'h0000010) begin n_err++; $display("FAIL ionly_addr: got %h want 0000010", mem_addr); end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_cmp++; if ({mem_read, i_ready} !== 2'b10) begin n_err++; $display("FAIL ionly_hold%0d: read,ready=%b want 10", i, {mem_read, i_ready}); end
        end
        tick;
        mem_rdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888; mem_ready = 1'b1;
        #1;
        n_cmp++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL ionly_ready: got %0b want 1", i_ready); end
        n_cmp++; if (d_ready !== 1'b0) begin n_err++; $display("FAIL ionly_dready: got %0b want 0", d_ready); end
        n_cmp++; if (i_rdata !== 128'h1111_2222_3333_4444_5555_6666_7777_8888) begin n_err++; $display("FAIL ionly_rdata: got %h", i_rdata); end
        tick;
        mem_ready = 1'b0; i_read = 1'b0;
        #1;
        n_cmp++; if ({mem_read, i_ready} !== 2'b00) begin n_err++; $display("FAIL ionly_release: read,ready=%b want 00", {mem_read, i_ready}); end
        tick;
    endtask

    task automatic test_back_to_back_ties;
        logic exp_d;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        i_addr = 28'h0000100; d_addr = 28'h0000200;
        i_read = 1'b1; d_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 0);
            tick;
            n_cmp++; if ({mem_read, mem_write} !== 2'b10) begin n_err++; $display("FAIL tie%0d_strobe: got %b want 10", k, {mem_read, mem_write}); end
            n_cmp++; if (mem_addr !== (exp_d ? 28'h0000200 : 28'h0000100)) begin n_err++; $display("FAIL tie%0d_addr: got %h want %s side", k, mem_addr, exp_d ? "D" : "I"); end
            mem_rdata = 128'(k + 5); mem_ready = 1'b1;
            #1;
            n_cmp++; if ({i_ready, d_ready} !== {~exp_d, exp_d}) begin n_err++; $display("FAIL tie%0d_ready: i,d=%b want %b", k, {i_ready, d_ready}, {~exp_d, exp_d}); end
            tick;
            mem_ready = 1'b0;
            if (exp_d) d_read = 1'b0; else i_read = 1'b0;
            #1;
            n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_err++; $display("FAIL tie%0d_release: got %b want 00", k, {mem_read, mem_write}); end
            tick;
            i_read = 1'b1; d_read = 1'b1;
        end
        i_read = 1'b0; d_read = 1'b0;
        tick;
    endtask

    task automatic test_read_write_both;
        d_read = 1'b1; d_write = 1'b1; d_addr = 28'h00000A0;
        d_wdata = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;
        tick;
        n_cmp++; if ({mem_read, mem_write} !== 2'b01) begin n_err++; $display("FAIL rw_write_first: read,write=%b want 01", {mem_read, mem_write}); end
        n_cmp++; if (mem_addr !== 28'h00000A0) begin n_err++; $display("FAIL rw_waddr: got %h want 00000a0", mem_addr); end
        n_cmp++; if (mem_wdata !== 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF) begin n_err++; $display("FAIL rw_wdata: got %h", mem_wdata); end
        tick;
        n_cmp++; if ({mem_read, mem_write} !== 2'b01) begin n_err++; $display("FAIL rw_write_hold: read,write=%b want 01", {mem_read, mem_write}); end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL rw_wready: got %0b want 1", d_ready); end
        tick;
        mem_ready = 1'b0; d_write = 1'b0;
        #1;
        n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_err++; $display("FAIL rw_release: got %b want 00", {mem_read, mem_write}); end
        tick;
        n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_err++; $display("FAIL rw_idle: got %b want 00", {mem_read, mem_write}); end
        tick;
        n_cmp++; if ({mem_read, mem_write} !== 2'b10) begin n_err++; $display("FAIL rw_read_second: read,write=%b want 10", {mem_read, mem_write}); end
        n_cmp++; if (mem_addr !== 28'h00000A0) begin n_err++; $display("FAIL rw_raddr: got %h want 00000a0", mem_addr); end
        mem_rdata = 128'hCAFE; mem_ready = 1'b1;
        #1;
        n_cmp++; if (d_ready !== 1'b1 || d_rdata !== 128'hCAFE) begin n_err++; $display("FAIL rw_rready: ready=%0b rdata=%h want 1/cafe", d_ready, d_rdata); end
        tick;
        mem_ready = 1'b0; d_read = 1'b0;
        tick;
    endtask

    task automatic test_spurious_ready;
        mem_ready = 1'b1;
        #1;
        n_cmp++; if ({i_ready, d_ready} !== 2'b00) begin n_err++; $display("FAIL spur_idle_ready: i,d=%b want 00", {i_ready, d_ready}); end
        tick;
        mem_ready = 1'b0;
        #1;
        n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_err++; $display("FAIL spur_idle_strobe: got %b want 00", {mem_read, mem_write}); end
        i_read = 1'b1; i_addr = 28'h0000030;
        tick;
        n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL spur_iread: got %0b want 1", mem_read); end
        mem_ready = 1'b1;
        tick;
        i_read = 1'b0;
        #1;
        n_cmp++; if ({i_ready, d_ready} !== 2'b00) begin n_err++; $display("FAIL spur_release_ready: i,d=%b want 00", {i_ready, d_ready}); end
        tick;
        mem_ready = 1'b0;
        d_read = 1'b1; d_addr = 28'h0000040;
        tick;
        n_cmp++; if (mem_read !== 1'b1 || mem_addr !== 28'h0000040) begin n_err++; $display("FAIL spur_next: read=%0b addr=%h want 1/0000040", mem_read, mem_addr); end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL spur_next_ready: got %0b want 1", d_ready); end
        tick;
        mem_ready = 1'b0; d_read = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_busy;
        d_read = 1'b1; d_addr = 28'h0000050;
        tick;
        n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL rmid_read: got %0b want 1", mem_read); end
        tick;
        #1 rst = 1'b1; mem_ready = 1'b1;
        #1;
        n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_err++; $display("FAIL rmid_strobes: got %b want 00", {mem_read, mem_write}); end
        n_cmp++; if (mem_addr !== '0) begin n_err++; $display("FAIL rmid_addr: got %h want 0", mem_addr); end
        n_cmp++; if (d_ready !== 1'b0) begin n_err++; $display("FAIL rmid_dready: got %0b want 0", d_ready); end
        tick;
        rst = 1'b0; mem_ready = 1'b0;
        tick;
        n_cmp++; if (mem_read !== 1'b1 || mem_addr !== 28'h0000050) begin n_err++; $display("FAIL rmid_rearb: read=%0b addr=%h want 1/0000050", mem_read, mem_addr); end
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0; d_read = 1'b0;
        tick;
    endtask

    task automatic test_drop_during_busy;
        i_read = 1'b1; i_addr = 28'h0000060;
        tick;
        i_read = 1'b0;
        n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL drop_read: got %0b want 1", mem_read); end
        tick;
        tick;
        n_cmp++; if (mem_read !== 1'b1 || mem_addr !== 28'h0000060) begin n_err++; $display("FAIL drop_hold: read=%0b addr=%h want 1/0000060", mem_read, mem_addr); end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL drop_ready: got %0b want 1", i_ready); end
        tick;
        mem_ready = 1'b0;
        #1;
        n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL drop_release: got %0b want 0", mem_read); end
        tick;
        tick;
        n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_err++; $display("FAIL drop_idle: got %b want 00", {mem_read, mem_write}); end
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        test_reset;
        test_i_only;
        test_back_to_back_ties;
        test_read_write_both;
        test_spurious_ready;
        test_reset_mid_busy;
        test_drop_during_busy;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
